// File: rtl/axi_reg_slice_if.sv
// AXI4 bundle (AW, W, B, AR, R) shared by both sides of the register slice.
// "slave" is the view of a block that receives requests; "master" issues them.
interface axi_reg_slice_if #(
   parameter int ID_WIDTH   = 10,
   parameter int ADDR_WIDTH = 64,
   parameter int DATA_WIDTH = 64,
   parameter int USER_WIDTH = 6
);
   // write address
   logic [ID_WIDTH-1:0]     awid;
   logic [ADDR_WIDTH-1:0]   awaddr;
   logic [7:0]              awlen;
   logic [2:0]              awsize;
   logic [1:0]              awburst;
   logic                    awlock;
   logic [3:0]              awcache;
   logic [2:0]              awprot;
   logic [3:0]              awregion;
   logic [3:0]              awqos;
   logic [USER_WIDTH-1:0]   awuser;
   logic                    awvalid;
   logic                    awready;
   // write data
   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;
   logic                    wlast;
   logic [USER_WIDTH-1:0]   wuser;
   logic                    wvalid;
   logic                    wready;
   // write response
   logic [ID_WIDTH-1:0]     bid;
   logic [1:0]              bresp;
   logic [USER_WIDTH-1:0]   buser;
   logic                    bvalid;
   logic                    bready;
   // read address
   logic [ID_WIDTH-1:0]     arid;
   logic [ADDR_WIDTH-1:0]   araddr;
   logic [7:0]              arlen;
   logic [2:0]              arsize;
   logic [1:0]              arburst;
   logic                    arlock;
   logic [3:0]              arcache;
   logic [2:0]              arprot;
   logic [3:0]              arregion;
   logic [3:0]              arqos;
   logic [USER_WIDTH-1:0]   aruser;
   logic                    arvalid;
   logic                    arready;
   // read data
   logic [ID_WIDTH-1:0]     rid;
   logic [DATA_WIDTH-1:0]   rdata;
   logic [1:0]              rresp;
   logic                    rlast;
   logic [USER_WIDTH-1:0]   ruser;
   logic                    rvalid;
   logic                    rready;

   modport slave (
      input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot,
             awregion, awqos, awuser, awvalid,
      output awready,
      input  wdata, wstrb, wlast, wuser, wvalid,
      output wready,
      output bid, bresp, buser, bvalid,
      input  bready,
      input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
             arregion, arqos, aruser, arvalid,
      output arready,
      output rid, rdata, rresp, rlast, ruser, rvalid,
      input  rready
   );

   modport master (
      output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot,
             awregion, awqos, awuser, awvalid,
      input  awready,
      output wdata, wstrb, wlast, wuser, wvalid,
      input  wready,
      input  bid, bresp, buser, bvalid,
      output bready,
      output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
             arregion, arqos, aruser, arvalid,
      input  arready,
      input  rid, rdata, rresp, rlast, ruser, rvalid,
      output rready
   );
endinterface

// File: rtl/axi_reg_slice.sv
// Full AXI4 register slice: five independent two-entry skid buffers that
// break every combinational path between the upstream and downstream ports.

// One channel slice: main + skid register, all outputs straight from flops.
module axi_reg_slice_chan #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] in_data_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] out_data_o
);
   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_e;

   state_e           state_q, state_d;
   logic             ready_q, valid_q;
   logic [WIDTH-1:0] main_q, main_d;
   logic [WIDTH-1:0] skid_q, skid_d;
   logic             accept, pop;

   // ready_q gates acceptance so valid input is ignored while full and
   // during the first cycle after reset release
   assign accept      = in_valid_i & ready_q;
   assign pop         = valid_q & out_ready_i;
   assign in_ready_o  = ready_q;
   assign out_valid_o = valid_q;
   assign out_data_o  = main_q;

   // next-state and register load selection
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
         EMPTY: begin
            if (accept) begin
               state_d = ONE;
               main_d  = in_data_i;
            end
         end
         ONE: begin
            if (accept && !pop) begin
               state_d = TWO;
               skid_d  = in_data_i;
            end else if (!accept && pop) begin
               state_d = EMPTY;
            end else if (accept && pop) begin
               main_d  = in_data_i;
            end
         end
         TWO: begin
            if (pop) begin
               state_d = ONE;
               main_d  = skid_q;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   // state and handshake flops; ready/valid are precomputed from next state
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= EMPTY;
         ready_q <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ready_q <= (state_d != TWO);
         valid_q <= (state_d != EMPTY);
      end
   end

   // payload registers, cleared so reset shows zeros on the bus
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         main_q <= '0;
         skid_q <= '0;
      end else begin
         main_q <= main_d;
         skid_q <= skid_d;
      end
   end
endmodule

module axi_reg_slice #(
   parameter int ID_WIDTH   = 10,
   parameter int ADDR_WIDTH = 64,
   parameter int DATA_WIDTH = 64,
   parameter int USER_WIDTH = 6
) (
   input  logic            clk,
   input  logic            rstn,
   axi_reg_slice_if.slave  s_axi,
   axi_reg_slice_if.master m_axi
);
   // bundle widths: AW/AR = id+addr+len8+size3+burst2+lock1+cache4+prot3+region4+qos4+user
   localparam int AXW = ID_WIDTH + ADDR_WIDTH + 29 + USER_WIDTH;
   localparam int WW  = DATA_WIDTH + DATA_WIDTH/8 + 1 + USER_WIDTH;
   localparam int BW  = ID_WIDTH + 2 + USER_WIDTH;
   localparam int RW  = ID_WIDTH + DATA_WIDTH + 3 + USER_WIDTH;

   logic [AXW-1:0] aw_in, aw_out, ar_in, ar_out;
   logic [WW-1:0]  w_in, w_out;
   logic [BW-1:0]  b_in, b_out;
   logic [RW-1:0]  r_in, r_out;

   assign aw_in = {s_axi.awid, s_axi.awaddr, s_axi.awlen, s_axi.awsize, s_axi.awburst,
                   s_axi.awlock, s_axi.awcache, s_axi.awprot, s_axi.awregion,
                   s_axi.awqos, s_axi.awuser};
   assign {m_axi.awid, m_axi.awaddr, m_axi.awlen, m_axi.awsize, m_axi.awburst,
           m_axi.awlock, m_axi.awcache, m_axi.awprot, m_axi.awregion,
           m_axi.awqos, m_axi.awuser} = aw_out;

   assign w_in = {s_axi.wdata, s_axi.wstrb, s_axi.wlast, s_axi.wuser};
   assign {m_axi.wdata, m_axi.wstrb, m_axi.wlast, m_axi.wuser} = w_out;

   assign b_in = {m_axi.bid, m_axi.bresp, m_axi.buser};
   assign {s_axi.bid, s_axi.bresp, s_axi.buser} = b_out;

   assign ar_in = {s_axi.arid, s_axi.araddr, s_axi.arlen, s_axi.arsize, s_axi.arburst,
                   s_axi.arlock, s_axi.arcache, s_axi.arprot, s_axi.arregion,
                   s_axi.arqos, s_axi.aruser};
   assign {m_axi.arid, m_axi.araddr, m_axi.arlen, m_axi.arsize, m_axi.arburst,
           m_axi.arlock, m_axi.arcache, m_axi.arprot, m_axi.arregion,
           m_axi.arqos, m_axi.aruser} = ar_out;

   assign r_in = {m_axi.rid, m_axi.rdata, m_axi.rresp, m_axi.rlast, m_axi.ruser};
   assign {s_axi.rid, s_axi.rdata, s_axi.rresp, s_axi.rlast, s_axi.ruser} = r_out;

   axi_reg_slice_chan #(.WIDTH(AXW)) u_aw (
      .clk(clk), .rstn(rstn),
      .in_valid_i(s_axi.awvalid), .in_ready_o(s_axi.awready), .in_data_i(aw_in),
      .out_valid_o(m_axi.awvalid), .out_ready_i(m_axi.awready), .out_data_o(aw_out));

   axi_reg_slice_chan #(.WIDTH(WW)) u_w (
      .clk(clk), .rstn(rstn),
      .in_valid_i(s_axi.wvalid), .in_ready_o(s_axi.wready), .in_data_i(w_in),
      .out_valid_o(m_axi.wvalid), .out_ready_i(m_axi.wready), .out_data_o(w_out));

   axi_reg_slice_chan #(.WIDTH(BW)) u_b (
      .clk(clk), .rstn(rstn),
      .in_valid_i(m_axi.bvalid), .in_ready_o(m_axi.bready), .in_data_i(b_in),
      .out_valid_o(s_axi.bvalid), .out_ready_i(s_axi.bready), .out_data_o(b_out));

   axi_reg_slice_chan #(.WIDTH(AXW)) u_ar (
      .clk(clk), .rstn(rstn),
      .in_valid_i(s_axi.arvalid), .in_ready_o(s_axi.arready), .in_data_i(ar_in),
      .out_valid_o(m_axi.arvalid), .out_ready_i(m_axi.arready), .out_data_o(ar_out));

   axi_reg_slice_chan #(.WIDTH(RW)) u_r (
      .clk(clk), .rstn(rstn),
      .in_valid_i(m_axi.rvalid), .in_ready_o(m_axi.rready), .in_data_i(r_in),
      .out_valid_o(s_axi.rvalid), .out_ready_i(s_axi.rready), .out_data_o(r_out));
endmodule

// File: tb/tb_axi_reg_slice.sv
// Bench for axi_reg_slice: directed AW/W/R/reset scenarios plus a randomised
// scoreboard run over all five channels. Channel index: 0 AW, 1 W, 2 AR, 3 B, 4 R.
module tb_axi_reg_slice;
   localparam int IDW = 10;
   localparam int AW  = 64;
   localparam int DW  = 64;
   localparam int UW  = 6;
   localparam int AXW = IDW + AW + 29 + UW;
   localparam int WW  = DW + DW/8 + 1 + UW;
   localparam int BW  = IDW + 2 + UW;
   localparam int RW  = IDW + DW + 3 + UW;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   axi_reg_slice_if #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .USER_WIDTH(UW)) s_if ();
   axi_reg_slice_if #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .USER_WIDTH(UW)) m_if ();

   axi_reg_slice #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .USER_WIDTH(UW)) dut (
      .clk(clk), .rstn(rstn), .s_axi(s_if), .m_axi(m_if));

   logic [4:0]   in_v, out_r;
   wire  [4:0]   in_r, out_v;
   logic [255:0] in_pl [5];
   wire  [255:0] out_pl [5];

   // channel inputs
   assign {s_if.awid, s_if.awaddr, s_if.awlen, s_if.awsize, s_if.awburst, s_if.awlock,
           s_if.awcache, s_if.awprot, s_if.awregion, s_if.awqos, s_if.awuser} = in_pl[0][AXW-1:0];
   assign {s_if.wdata, s_if.wstrb, s_if.wlast, s_if.wuser} = in_pl[1][WW-1:0];
   assign {s_if.arid, s_if.araddr, s_if.arlen, s_if.arsize, s_if.arburst, s_if.arlock,
           s_if.arcache, s_if.arprot, s_if.arregion, s_if.arqos, s_if.aruser} = in_pl[2][AXW-1:0];
   assign {m_if.bid, m_if.bresp, m_if.buser} = in_pl[3][BW-1:0];
   assign {m_if.rid, m_if.rdata, m_if.rresp, m_if.rlast, m_if.ruser} = in_pl[4][RW-1:0];
   assign s_if.awvalid = in_v[0];
   assign s_if.wvalid  = in_v[1];
   assign s_if.arvalid = in_v[2];
   assign m_if.bvalid  = in_v[3];
   assign m_if.rvalid  = in_v[4];
   assign m_if.awready = out_r[0];
   assign m_if.wready  = out_r[1];
   assign m_if.arready = out_r[2];
   assign s_if.bready  = out_r[3];
   assign s_if.rready  = out_r[4];

   // channel outputs
   assign in_r  = {m_if.rready, m_if.bready, s_if.arready, s_if.wready, s_if.awready};
   assign out_v = {s_if.rvalid, s_if.bvalid, m_if.arvalid, m_if.wvalid, m_if.awvalid};
   assign out_pl[0] = 256'({m_if.awid, m_if.awaddr, m_if.awlen, m_if.awsize, m_if.awburst, m_if.awlock,
                            m_if.awcache, m_if.awprot, m_if.awregion, m_if.awqos, m_if.awuser});
   assign out_pl[1] = 256'({m_if.wdata, m_if.wstrb, m_if.wlast, m_if.wuser});
   assign out_pl[2] = 256'({m_if.arid, m_if.araddr, m_if.arlen, m_if.arsize, m_if.arburst, m_if.arlock,
                            m_if.arcache, m_if.arprot, m_if.arregion, m_if.arqos, m_if.aruser});
   assign out_pl[3] = 256'({s_if.bid, s_if.bresp, s_if.buser});
   assign out_pl[4] = 256'({s_if.rid, s_if.rdata, s_if.rresp, s_if.rlast, s_if.ruser});

   int ntests = 0;
   int nfail  = 0;

   task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
      ntests++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   function automatic int pw(input int ch);
      case (ch)
         0, 2:    return AXW;
         1:       return WW;
         3:       return BW;
         default: return RW;
      endcase
   endfunction

   function automatic logic [255:0] rnd_pl(input int ch);
      logic [255:0] v;
      for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
      return v & ((256'd1 << pw(ch)) - 256'd1);
   endfunction

   function automatic logic [255:0] wbeat(input int k);
      return 256'({64'(k), 8'hFF, (k == 4), 6'd0});
   endfunction

   function automatic logic [255:0] rbeat(input int k);
      return 256'({10'(k), 64'(k), 2'b00, (k == 15), 6'd0});
   endfunction

   task automatic chk_all_zero(input string tag);
      for (int ch = 0; ch < 5; ch++) begin
         chk($sformatf("%s_ch%0d_ready", tag, ch), 256'(in_r[ch]), 256'(0));
         chk($sformatf("%s_ch%0d_valid", tag, ch), 256'(out_v[ch]), 256'(0));
         chk($sformatf("%s_ch%0d_payload", tag, ch), out_pl[ch], 256'(0));
      end
   endtask

   // scoreboard for the randomised run
   logic [255:0] sb [5][64];
   int           wr [5];
   int           rd [5];
   logic [4:0]   hold;
   logic [255:0] prev [5];

   task automatic rand_cycle(input bit drain);
      for (int ch = 0; ch < 5; ch++) begin
         if (hold[ch]) begin
            chk($sformatf("ch%0d_stable_valid", ch), 256'(out_v[ch]), 256'(1));
            chk($sformatf("ch%0d_stable_payload", ch), out_pl[ch], prev[ch]);
         end
         out_r[ch] = drain ? 1'b1 : ($urandom_range(0, 1) == 1);
         in_v[ch]  = drain ? 1'b0 : ($urandom_range(0, 3) != 0);
         in_pl[ch] = rnd_pl(ch);
         if (out_v[ch] && out_r[ch]) begin
            chk($sformatf("ch%0d_pending", ch), 256'(wr[ch] != rd[ch]), 256'(1));
            if (wr[ch] != rd[ch]) begin
               chk($sformatf("ch%0d_order", ch), out_pl[ch], sb[ch][rd[ch] % 64]);
               rd[ch]++;
            end
         end
         if (in_v[ch] && in_r[ch]) begin
            sb[ch][wr[ch] % 64] = in_pl[ch];
            wr[ch]++;
         end
         hold[ch] = out_v[ch] & ~out_r[ch];
         prev[ch] = out_pl[ch];
      end
      step();
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [255:0] awp;
      int k, exp_b;
      in_v  = '0;
      out_r = '0;
      for (int ch = 0; ch < 5; ch++) in_pl[ch] = '0;
      awp = 256'({10'h5, 64'h8000_0000, 8'd3, 3'd3, 2'b01, 1'b0, 4'h3, 3'd0, 4'd0, 4'd0, 6'h2});

      // reset state, then ready rises one edge after release
      step();
      chk_all_zero("rst");
      rstn = 1'b1;
      #1;
      chk("rel_ready_low", 256'(in_r), 256'(0));
      step();
      chk("rel_ready_high", 256'(in_r), 256'(5'b11111));
      chk("rel_valid_low", 256'(out_v), 256'(0));

      // single AW with downstream always ready
      in_v[0]  = 1'b1;
      in_pl[0] = awp;
      out_r[0] = 1'b1;
      chk("aw_ready", 256'(in_r[0]), 256'(1));
      step();
      in_v[0] = 1'b0;
      chk("aw_valid", 256'(out_v[0]), 256'(1));
      chk("aw_payload", out_pl[0], awp);
      chk("aw_addr", 256'(m_if.awaddr), 256'(64'h8000_0000));
      chk("aw_len", 256'(m_if.awlen), 256'(3));
      step();
      chk("aw_valid_1cyc", 256'(out_v[0]), 256'(0));
      out_r[0] = 1'b0;

      // W burst with downstream stalled for 3 cycles
      k = 1;
      exp_b = 1;
      for (int c = 0; c < 9; c++) begin
         out_r[1] = (c >= 3);
         in_v[1]  = (k <= 4);
         in_pl[1] = (k <= 4) ? wbeat(k) : 256'(0);
         if (c < 2)  chk($sformatf("w_ready_c%0d", c), 256'(in_r[1]), 256'(1));
         if (c == 2 || c == 3) chk($sformatf("w_ready_drop_c%0d", c), 256'(in_r[1]), 256'(0));
         if (c < 3)  chk($sformatf("w_valid_c%0d", c), 256'(out_v[1]), (c == 0) ? 256'(0) : 256'(1));
         if (out_v[1] && out_r[1]) begin
            chk($sformatf("w_beat%0d", exp_b), out_pl[1], wbeat(exp_b));
            chk($sformatf("w_last%0d", exp_b), 256'(m_if.wlast), 256'(exp_b == 4));
            exp_b++;
         end
         if (in_v[1] && in_r[1]) k++;
         step();
      end
      chk("w_count", 256'(exp_b), 256'(5));
      in_v[1]  = 1'b0;
      out_r[1] = 1'b0;

      // back-to-back R stream with rready high
      out_r[4] = 1'b1;
      for (int c = 0; c < 17; c++) begin
         in_v[4]  = (c < 16);
         in_pl[4] = (c < 16) ? rbeat(c) : 256'(0);
         if (c < 16) chk($sformatf("r_ready_c%0d", c), 256'(in_r[4]), 256'(1));
         if (c == 0) chk("r_valid_c0", 256'(out_v[4]), 256'(0));
         else begin
            chk($sformatf("r_valid_c%0d", c), 256'(out_v[4]), 256'(1));
            chk($sformatf("r_beat%0d", c - 1), out_pl[4], rbeat(c - 1));
         end
         step();
      end
      chk("r_idle", 256'(out_v[4]), 256'(0));
      in_v[4]  = 1'b0;
      out_r[4] = 1'b0;

      // fill AW and R to two entries, then reset mid-operation
      in_v[0]  = 1'b1;
      in_pl[0] = awp;
      in_v[4]  = 1'b1;
      in_pl[4] = rbeat(7);
      step();
      step();
      chk("full_aw_ready", 256'(in_r[0]), 256'(0));
      chk("full_r_ready", 256'(in_r[4]), 256'(0));
      chk("full_aw_valid", 256'(out_v[0]), 256'(1));
      chk("full_r_valid", 256'(out_v[4]), 256'(1));
      in_v = '0;
      #2;
      rstn = 1'b0;
      #1;
      chk_all_zero("midrst");
      step();
      chk_all_zero("midrst_hold");
      rstn  = 1'b1;
      out_r = 5'b11111;
      #1;
      chk("midrel_ready_low", 256'(in_r), 256'(0));
      step();
      chk("midrel_ready_high", 256'(in_r), 256'(5'b11111));
      chk("midrel_no_stale0", 256'(out_v), 256'(0));
      step();
      chk("midrel_no_stale1", 256'(out_v), 256'(0));

      // randomised traffic on all channels, then drain
      hold = '0;
      for (int ch = 0; ch < 5; ch++) begin
         wr[ch] = 0;
         rd[ch] = 0;
         prev[ch] = '0;
      end
      repeat (10000) rand_cycle(1'b0);
      repeat (8) rand_cycle(1'b1);
      for (int ch = 0; ch < 5; ch++)
         chk($sformatf("ch%0d_drained", ch), 256'(rd[ch]), 256'(wr[ch]));

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end
endmodule

// File: doc/axi_reg_slice.md
AXI_REG_SLICE -- requirements
Module: axi_reg_slice

Interface
REQ-001 SHALL have parameter ID_WIDTH, default 10, AXI ID width on all channels.
REQ-002 SHALL have parameter ADDR_WIDTH, default 64, AW/AR address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 64, W/R data width; wstrb width is DATA_WIDTH/8 on both sides.
REQ-004 SHALL have parameter USER_WIDTH, default 6, width of every user field.
REQ-005 SHALL use one clock and an asynchronous active-low reset: clk input 1 (all state on rising edge); rstn input 1 (async assert, active low).
REQ-006 SHALL have s_axi_aw{id,addr,len[8],size[3],burst[2],lock[1],cache[4],prot[3],region[4],qos[4],user} input, plus s_axi_awvalid input 1 and s_axi_awready output 1: upstream write address.
REQ-007 SHALL have s_axi_w{data,strb,last,user} input, plus s_axi_wvalid input 1 and s_axi_wready output 1: upstream write data.
REQ-008 SHALL have s_axi_b{id,resp[2],user} output, plus s_axi_bvalid output 1 and s_axi_bready input 1: upstream write response.
REQ-009 SHALL have s_axi_ar* (same fields as AW) input, plus s_axi_arvalid input 1 and s_axi_arready output 1: upstream read address.
REQ-010 SHALL have s_axi_r{id,data,resp[2],last,user} output, plus s_axi_rvalid output 1 and s_axi_rready input 1: upstream read data.
REQ-011 SHALL have the m_axi_* mirror of REQ-006..010 with directions reversed: downstream port toward the slave.

Function
REQ-012 SHALL contain five independent channel slices: AW, W and AR forward (s->m); B and R reverse (m->s); each slice carries its full payload as one bundle.
REQ-013 Each slice SHALL hold a main register and a skid register, with state EMPTY, ONE or TWO.
REQ-014 EMPTY: in_ready=1, out_valid=0; accept (in_valid&in_ready) -> ONE with the beat in main.
REQ-015 ONE: in_ready=1, out_valid=1. Accept without pop -> TWO, new beat into skid. Pop (out_valid&out_ready) without accept -> EMPTY. Accept and pop together -> ONE, new beat into main.
REQ-016 TWO: in_ready=0, out_valid=1; pop -> ONE, skid moved into main; no other transition.
REQ-017 in_ready, out_valid and out payload SHALL be driven directly from flops, with no combinational path from any input port to any output port.
REQ-018 Latency SHALL be exactly 1 cycle: a beat accepted at edge N is presented on the output after edge N with out_valid=1 when the slice was EMPTY, or ONE with a pop at the same edge.
REQ-019 Sustained throughput SHALL be 1 beat/cycle per channel when the output is continuously ready.
REQ-020 Beats SHALL leave each slice in acceptance order, with no loss, duplication or alteration of any payload bit.
REQ-021 While out_valid=1 and out_ready=0, out payload and out_valid SHALL hold stable.
REQ-022 Channels SHALL be mutually independent: no ordering or stall coupling between AW, W, B, AR and R.
REQ-023 in_valid SHALL be ignored whenever in_ready=0, including when in_valid is asserted in TWO.

Reset
REQ-024 rstn low SHALL asynchronously force every slice to EMPTY, and force all *valid outputs, all *ready outputs and all payload outputs to 0.
REQ-025 Every *ready output SHALL first rise to 1 on the first rising clk edge after rstn deasserts.
REQ-026 Reset asserted mid-operation SHALL discard all buffered beats; none appears on any output after reset.

Verification
REQ-027 Single AW, awaddr=0x8000_0000, awlen=3, m_axi_awready=1: m_axi_awvalid high exactly 1 cycle, one cycle after the handshake, with the same payload.
REQ-028 W burst of 4 beats (wdata=1,2,3,4; wlast on beat 4), m_axi_wready held 0 for 3 cycles then 1: s_axi_wready drops after 2 beats are accepted; output order is 1,2,3,4; wlast appears only on beat 4.
REQ-029 Back-to-back R stream of 16 beats, rready=1 throughout: 16 beats delivered in 16 consecutive cycles; rid and rdata identical and in order.
REQ-030 Random valid/ready toggling on all five channels for 10k cycles: scoreboard shows zero mismatches and no payload change while valid&!ready.
REQ-031 rstn pulsed low with AW and R slices in TWO: all outputs read 0 during reset; after release no stale beat emerges; the ready outputs rise one edge later.
